// File: rtl/ram_port_arbiter.sv
// ----------------------------------------------------------------------------
// ram_port_arbiter
//
// Shares one dual-port RAM (write port + registered read port, both on clk)
// among NREQ requesters. At most one beat is accepted per cycle. A beat from
// the winning requester is steered to the RAM write or read port. Grants
// rotate round-robin between bursts. A multi-beat burst locks the grant to
// its owner until req_last, or until MAX_BURST beats force a release.
// Read data comes back on a tagged response channel one cycle after the
// read is accepted.
//
// Ports
//   clk        in   single clock (RAM wclk/rclk are tied to it)
//   rst        in   synchronous active-high reset
//   req        in   [NREQ]        per-requester beat request, held until granted
//   req_we     in   [NREQ]        1 = write beat, 0 = read beat
//   req_last   in   [NREQ]        final beat of the requester's burst
//   req_addr   in   [NREQ*AW]     packed addresses, requester i at [i*AW +: AW]
//   req_wdata  in   [NREQ*WIDTH]  packed write data, requester i at [i*WIDTH +: WIDTH]
//   gnt        out  [NREQ]        one-hot combinational grant
//   ram_wenc   out                RAM write enable
//   ram_waddr  out  [AW]          RAM write address
//   ram_wdata  out  [WIDTH]       RAM write data
//   ram_renc   out                RAM read enable
//   ram_raddr  out  [AW]          RAM read address
//   ram_rdata  in   [WIDTH]       RAM registered read data
//   rsp_valid  out                read response valid
//   rsp_id     out  [IW]          requester index of the response
//   rsp_data   out  [WIDTH]       read response data
//   busy       out                high while a burst holds the lock
// ----------------------------------------------------------------------------
module ram_port_arbiter #(
  parameter int NREQ      = 4,
  parameter int DEPTH     = 16,
  parameter int WIDTH     = 8,
  parameter int MAX_BURST = 8,
  localparam int AW       = $clog2(DEPTH),
  localparam int IW       = $clog2(NREQ),
  localparam int CW       = $clog2(MAX_BURST + 1)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NREQ-1:0]       req,
  input  logic [NREQ-1:0]       req_we,
  input  logic [NREQ-1:0]       req_last,
  input  logic [NREQ*AW-1:0]    req_addr,
  input  logic [NREQ*WIDTH-1:0] req_wdata,
  output logic [NREQ-1:0]       gnt,
  output logic                  ram_wenc,
  output logic [AW-1:0]         ram_waddr,
  output logic [WIDTH-1:0]      ram_wdata,
  output logic                  ram_renc,
  output logic [AW-1:0]         ram_raddr,
  input  logic [WIDTH-1:0]      ram_rdata,
  output logic                  rsp_valid,
  output logic [IW-1:0]         rsp_id,
  output logic [WIDTH-1:0]      rsp_data,
  output logic                  busy
);

  typedef enum logic {IDLE = 1'b0, LOCK = 1'b1} state_t;

  state_t          state_q, state_d;
  logic [IW-1:0]   ptr_q, ptr_d;
  logic [IW-1:0]   owner_q, owner_d;
  logic [CW-1:0]   beat_cnt_q, beat_cnt_d;
  logic            rsp_valid_q, rsp_valid_d;
  logic [IW-1:0]   rsp_id_q, rsp_id_d;

  logic [AW-1:0]    addr_arr  [NREQ];
  logic [WIDTH-1:0] wdata_arr [NREQ];

  logic            sel_valid;
  logic [IW-1:0]   sel_idx;
  logic [IW-1:0]   rr_cand;
  logic [IW-1:0]   cur_idx;
  logic            accept;
  logic            beat_end;

  // Unpack the per-requester address and data slices.
  for (genvar gi = 0; gi < NREQ; gi++) begin : g_unpack
    assign addr_arr[gi]  = req_addr[gi*AW +: AW];
    assign wdata_arr[gi] = req_wdata[gi*WIDTH +: WIDTH];
  end

  // (base + off) mod NREQ; works for non-power-of-two NREQ.
  function automatic logic [IW-1:0] wrap_add(input logic [IW-1:0] base, input int off);
    int s;
    s = int'(base) + off;
    if (s >= NREQ) s = s - NREQ;
    return IW'(s);
  endfunction

  // Round-robin search starting at ptr_q, wrapping past NREQ-1.
  always_comb begin
    sel_valid = 1'b0;
    sel_idx   = '0;
    rr_cand   = '0;
    for (int k = 0; k < NREQ; k++) begin
      rr_cand = wrap_add(ptr_q, k);
      if (!sel_valid && req[rr_cand]) begin
        sel_valid = 1'b1;
        sel_idx   = rr_cand;
      end
    end
  end

  // While locked only the owner can be served; other requesters wait even
  // when the owner pauses mid-burst.
  assign cur_idx  = (state_q == LOCK) ? owner_q : sel_idx;
  assign accept   = |(req & gnt);
  // In LOCK beat_cnt_q < MAX_BURST, so the +1 cannot overflow CW bits.
  assign beat_end = req_last[cur_idx] | ((beat_cnt_q + CW'(1)) == CW'(MAX_BURST));

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      ptr_q       <= '0;
      owner_q     <= '0;
      beat_cnt_q  <= '0;
      rsp_valid_q <= 1'b0;
      rsp_id_q    <= '0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      owner_q     <= owner_d;
      beat_cnt_q  <= beat_cnt_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_id_q    <= rsp_id_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d    = state_q;
    ptr_d      = ptr_q;
    owner_d    = owner_q;
    beat_cnt_d = beat_cnt_q;
    if (accept) begin
      case (state_q)
        IDLE: begin
          if (!beat_end) begin
            state_d    = LOCK;
            owner_d    = cur_idx;
            beat_cnt_d = CW'(1);
          end else begin
            ptr_d = wrap_add(cur_idx, 1);
          end
        end
        LOCK: begin
          if (!beat_end) begin
            beat_cnt_d = beat_cnt_q + CW'(1);
          end else begin
            state_d    = IDLE;
            ptr_d      = wrap_add(owner_q, 1);
            beat_cnt_d = '0;
          end
        end
        default: ;
      endcase
    end
  end

  // Output logic. The grant is held low during reset so nothing reaches the
  // RAM and no response is generated for that cycle.
  always_comb begin
    gnt = '0;
    if (!rst) begin
      if (state_q == IDLE) begin
        if (sel_valid) gnt[sel_idx] = 1'b1;
      end else begin
        gnt[owner_q] = req[owner_q];
      end
    end
    ram_wenc  = accept & req_we[cur_idx];
    ram_renc  = accept & ~req_we[cur_idx];
    ram_waddr = addr_arr[cur_idx];
    ram_raddr = addr_arr[cur_idx];
    ram_wdata = wdata_arr[cur_idx];
  end

  // Response tag follows the registered RAM read by exactly one cycle.
  assign rsp_valid_d = ram_renc;
  assign rsp_id_d    = ram_renc ? cur_idx : rsp_id_q;

  assign rsp_valid = rsp_valid_q;
  assign rsp_id    = rsp_id_q;
  assign rsp_data  = ram_rdata;
  assign busy      = (state_q == LOCK);

endmodule
